// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction-class encoding and the
// field bundle handed to the encoder. Also used by the controller decoder.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Class codes 6 and 7 are reserved and treated as illegal.
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_ADDI = 3'd4,
    CLS_J    = 3'd5
  } instr_class_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;
  } instr_fields_t;

  function automatic logic class_legal(input logic [2:0] c);
    return (c <= 3'd5);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Instruction-field bundle handshake: producer (master) -> loader (slave).
interface instr_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic        in_last;

  modport master (
    output in_valid, in_class, rs, rt, rd, shamt, funct, imm, jaddr, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, rs, rt, rd, shamt, funct, imm, jaddr, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational packing of instruction fields into a 32-bit MIPS word.
// legal is low for reserved classes; word is zero in that case.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [2:0]    in_class,
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          legal
);

  // Select opcode and field layout by class
  always_comb begin
    word  = '0;
    legal = class_legal(in_class);
    case (in_class)
      CLS_R:    word = {OP_R,    f.rs, f.rt, f.rd, f.shamt, f.funct};
      CLS_LW:   word = {OP_LW,   f.rs, f.rt, f.imm};
      CLS_SW:   word = {OP_SW,   f.rs, f.rt, f.imm};
      CLS_BEQ:  word = {OP_BEQ,  f.rs, f.rt, f.imm};
      CLS_ADDI: word = {OP_ADDI, f.rs, f.rt, f.imm};
      CLS_J:    word = {OP_J,    f.jaddr};
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts field bundles, encodes them and writes
// them to consecutive word addresses from 0, one word per two cycles.
// Optional build macro INSTR_LOADER_CHECKSUM_EN enables the running XOR
// checksum of written words; otherwise checksum is tied to zero.
module instr_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [31:0]       checksum
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              last_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  instr_fields_t     fields;

  assign fields = '{rs: bus.rs, rt: bus.rt, rd: bus.rd, shamt: bus.shamt,
                    funct: bus.funct, imm: bus.imm, jaddr: bus.jaddr};

  instr_encoder u_enc (
    .in_class (bus.in_class),
    .f        (fields),
    .word     (enc_word),
    .legal    (enc_legal)
  );

  assign bus.in_ready = (state == ACCEPT);
  assign imem_we      = (state == WRITE);
  assign busy         = (state == ACCEPT) || (state == WRITE);
  assign done         = (state == DONE);

  // Session FSM, write address/data registers and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      last_q       <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ACCEPT;
            addr_cnt     <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        ACCEPT: begin
          if (bus.in_valid) begin
            if (enc_legal) begin
              imem_wdata <= enc_word;
              imem_addr  <= addr_cnt;
              last_q     <= bus.in_last;
              state      <= WRITE;
            end else begin
              // Illegal bundle is consumed without a write
              err_illegal <= 1'b1;
              if (bus.in_last) state <= DONE;
            end
          end
        end
        WRITE: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (last_q) begin
            state <= DONE;
          end else if (imem_addr == LAST_ADDR) begin
            // Memory full with more instructions pending: stop, never wrap
            err_overflow <= 1'b1;
            state        <= DONE;
          end else begin
            state <= ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every word written this session
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum_q <= '0;
    else if (start && ((state == IDLE) || (state == DONE)))
      csum_q <= '0;
    else if (state == WRITE)
      csum_q <= csum_q ^ imem_wdata;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (ADDR_W=8 main instance,
// ADDR_W=2 instance for the memory-full case).
module tb_instr_loader;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_loader_if bus_a ();
  instr_loader_if bus_b ();

  logic       we_a, busy_a, done_a, eill_a, eovf_a;
  logic [7:0] addr_a;
  logic [31:0] wdata_a, csum_a;
  logic       we_b, busy_b, done_b, eill_b, eovf_b;
  logic [1:0] addr_b;
  logic [31:0] wdata_b, csum_b;

  instr_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a.slave),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err_illegal(eill_a),
    .err_overflow(eovf_a), .checksum(csum_a)
  );

  instr_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b.slave),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err_illegal(eill_b),
    .err_overflow(eovf_b), .checksum(csum_b)
  );

  function automatic logic [31:0] csum_exp(input logic [31:0] v);
`ifdef INSTR_LOADER_CHECKSUM_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  // Present one bundle on bus_a and return 1 time unit after it is taken
  task automatic drive_a(input logic [2:0] c, input logic [4:0] rs, rt, rd, sh,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] ja, input logic last);
    int n;
    @(negedge clk);
    bus_a.in_class = c; bus_a.rs = rs; bus_a.rt = rt; bus_a.rd = rd;
    bus_a.shamt = sh; bus_a.funct = fn; bus_a.imm = imm; bus_a.jaddr = ja;
    bus_a.in_last = last; bus_a.in_valid = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%0b want 1", bus_a.in_ready);
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.in_ready, we_a, addr_a, wdata_a, busy_a, done_a, eill_a, eovf_a, csum_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a got rdy=%0b we=%0b addr=%h wd=%h busy=%0b done=%0b ei=%0b eo=%0b cs=%h want all 0",
               bus_a.in_ready, we_a, addr_a, wdata_a, busy_a, done_a, eill_a, eovf_a, csum_a);
    end
    checks++;
    if ({bus_b.in_ready, we_b, addr_b, wdata_b, busy_b, done_b, eovf_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b got we=%0b busy=%0b done=%0b want 0", we_b, busy_b, done_b);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (we_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got we=%0b busy=%0b want 0 0", we_a, busy_a);
    end
  endtask

  task automatic test_rtype();
    pulse_start_a();
    checks++;
    if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_accept got busy=%0b rdy=%0b want 1 1", busy_a, bus_a.in_ready);
    end
    drive_a(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0, 1'b1);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 32'h00221820) begin
      errors++;
      $display("FAIL rtype_write got we=%0b addr=%h wd=%h want 1 00 00221820", we_a, addr_a, wdata_a);
    end
    tick();
    checks++;
    if (we_a !== 1'b0 || done_a !== 1'b1 || csum_a !== csum_exp(32'h00221820)) begin
      errors++;
      $display("FAIL rtype_done got we=%0b done=%0b cs=%h want 0 1 %h", we_a, done_a, csum_a, csum_exp(32'h00221820));
    end
  endtask

  task automatic test_lw();
    pulse_start_a();
    drive_a(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b1);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 32'h8C080004) begin
      errors++;
      $display("FAIL lw_write got we=%0b addr=%h wd=%h want 1 00 8c080004", we_a, addr_a, wdata_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.in_ready !== 1'b0 || csum_a !== csum_exp(32'h8C080004)) begin
      errors++;
      $display("FAIL lw_done got done=%0b busy=%0b rdy=%0b cs=%h want 1 0 0 %h",
               done_a, busy_a, bus_a.in_ready, csum_a, csum_exp(32'h8C080004));
    end
  endtask

  // J then BEQ, with a stray start pulse mid-session that must be ignored
  task automatic test_back_to_back();
    pulse_start_a();
    drive_a(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010, 1'b0);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 32'h08000010) begin
      errors++;
      $display("FAIL j_write got we=%0b addr=%h wd=%h want 1 00 08000010", we_a, addr_a, wdata_a);
    end
    pulse_start_a();
    drive_a(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b1);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd1 || wdata_a !== 32'h1022FFFF) begin
      errors++;
      $display("FAIL beq_write got we=%0b addr=%h wd=%h want 1 01 1022ffff", we_a, addr_a, wdata_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || csum_a !== csum_exp(32'h1822FFEF)) begin
      errors++;
      $display("FAIL b2b_done got done=%0b cs=%h want 1 %h", done_a, csum_a, csum_exp(32'h1822FFEF));
    end
  endtask

  task automatic test_illegal();
    pulse_start_a();
    checks++;
    if (eill_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL start_clears got ei=%0b done=%0b want 0 0", eill_a, done_a);
    end
    drive_a(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 1'b0);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 32'h20010005) begin
      errors++;
      $display("FAIL addi0_write got we=%0b addr=%h wd=%h want 1 00 20010005", we_a, addr_a, wdata_a);
    end
    drive_a(3'd7, 5'd3, 5'd3, 5'd3, 5'd3, 6'd3, 16'h3333, 26'h0, 1'b0);
    checks++;
    if (we_a !== 1'b0 || eill_a !== 1'b1 || bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_consume got we=%0b ei=%0b rdy=%0b want 0 1 1", we_a, eill_a, bus_a.in_ready);
    end
    drive_a(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0006, 26'h0, 1'b1);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 8'd1 || wdata_a !== 32'h20010006) begin
      errors++;
      $display("FAIL addi1_write got we=%0b addr=%h wd=%h want 1 01 20010006", we_a, addr_a, wdata_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || eill_a !== 1'b1 || csum_a !== csum_exp(32'h00000003)) begin
      errors++;
      $display("FAIL illegal_done got done=%0b ei=%0b cs=%h want 1 1 %h", done_a, eill_a, csum_a, csum_exp(32'h3));
    end
    // Illegal bundle flagged last ends the session without a write
    pulse_start_a();
    drive_a(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b1);
    checks++;
    if (we_a !== 1'b0 || done_a !== 1'b1 || eill_a !== 1'b1) begin
      errors++;
      $display("FAIL illegal_last got we=%0b done=%0b ei=%0b want 0 1 1", we_a, done_a, eill_a);
    end
  endtask

  task automatic test_reset_mid_write();
    int wes;
    pulse_start_a();
    drive_a(3'd4, 5'd2, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0, 1'b0);
    checks++;
    if (we_a !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_setup got we=%0b want 1", we_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.in_ready, we_a, addr_a, wdata_a, busy_a, done_a, eill_a, eovf_a, csum_a} !== '0) begin
      errors++;
      $display("FAIL midwrite_reset got we=%0b addr=%h wd=%h busy=%0b done=%0b want all 0",
               we_a, addr_a, wdata_a, busy_a, done_a);
    end
    @(negedge clk); reset = 1'b0;
    wes = 0;
    repeat (4) begin tick(); if (we_a !== 1'b0 || busy_a !== 1'b0) wes++; end
    checks++;
    if (wes != 0) begin
      errors++;
      $display("FAIL midwrite_after got %0d active cycles want 0", wes);
    end
  endtask

  task automatic test_overflow();
    int n, wes, rdys;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_b.in_class = 3'd0; bus_b.rs = 5'd0; bus_b.rt = 5'd0; bus_b.rd = 5'(i);
      bus_b.shamt = 5'd0; bus_b.funct = 6'd0; bus_b.imm = 16'h0; bus_b.jaddr = 26'h0;
      bus_b.in_last = 1'b0; bus_b.in_valid = 1'b1;
      n = 0;
      while (!bus_b.in_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
      checks++;
      if (n >= 20 || we_b !== 1'b1 || addr_b !== 2'(i) || wdata_b !== (32'(i) << 11)) begin
        errors++;
        $display("FAIL ovf_write%0d got we=%0b addr=%0d wd=%h want 1 %0d %h", i, we_b, addr_b, wdata_b, i, 32'(i) << 11);
      end
    end
    tick();
    checks++;
    if (done_b !== 1'b1 || eovf_b !== 1'b1 || busy_b !== 1'b0 || eill_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags got done=%0b eo=%0b busy=%0b ei=%0b want 1 1 0 0", done_b, eovf_b, busy_b, eill_b);
    end
    // Fifth bundle must never be taken
    @(negedge clk);
    bus_b.rd = 5'd4; bus_b.in_valid = 1'b1;
    wes = 0; rdys = 0;
    repeat (6) begin @(negedge clk); if (we_b) wes++; if (bus_b.in_ready) rdys++; end
    bus_b.in_valid = 1'b0;
    checks++;
    if (wes != 0 || rdys != 0 || done_b !== 1'b1 || eovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fifth got we_cycles=%0d rdy_cycles=%0d done=%0b eo=%0b want 0 0 1 1", wes, rdys, done_b, eovf_b);
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_class = '0; bus_a.rs = '0; bus_a.rt = '0;
    bus_a.rd = '0; bus_a.shamt = '0; bus_a.funct = '0; bus_a.imm = '0;
    bus_a.jaddr = '0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_class = '0; bus_b.rs = '0; bus_b.rt = '0;
    bus_b.rd = '0; bus_b.shamt = '0; bus_b.funct = '0; bus_b.imm = '0;
    bus_b.jaddr = '0; bus_b.in_last = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a load session from address 0.
REQ-005 in_valid  input  1  instruction-field bundle valid.
REQ-006 in_ready  output  1  loader accepts bundle this cycle.
REQ-007 in_class  input  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J; 6-7 illegal.
REQ-008 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-009 funct  input  6  R-type function field.
REQ-010 imm  input  16  I-type immediate.
REQ-011 jaddr  input  26  J-type target.
REQ-012 in_last  input  1  bundle is the final instruction of the session.
REQ-013 imem_we  output  1  instruction-memory write strobe.
REQ-014 imem_addr  output  ADDR_W  word address of write.
REQ-015 imem_wdata  output  32  encoded instruction word.
REQ-016 busy  output  1  session in progress.
REQ-017 done  output  1  session finished; held until next start or reset.
REQ-018 err_illegal  output  1  sticky: illegal in_class seen this session.
REQ-019 err_overflow  output  1  sticky: memory filled before in_last.
REQ-020 checksum  output  32  running XOR of written words (see Configuration).

Function
REQ-021 Opcodes SHALL be R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-022 Packing: R={op,rs,rt,rd,shamt,funct}; LW/SW/BEQ/ADDI={op,rs,rt,imm}; J={op,jaddr}.
REQ-023 FSM states IDLE, ACCEPT, WRITE, DONE; in_ready=1 only in ACCEPT.
REQ-024 IDLE or DONE + start -> ACCEPT; address counter, sticky errors, checksum cleared; done deasserts.
REQ-025 start while in ACCEPT or WRITE SHALL be ignored.
REQ-026 ACCEPT, in_valid=1, legal class: word and address registered, -> WRITE; imem_we=1 exactly the next cycle (latency 1).
REQ-027 ACCEPT, in_valid=1, illegal class: bundle consumed, nothing written, err_illegal set, stay ACCEPT; if in_last also set -> DONE.
REQ-028 WRITE: address counter increments after the write; -> DONE if in_last was set or address was DEPTH-1, else -> ACCEPT.
REQ-029 Write at address DEPTH-1 without in_last: err_overflow set, -> DONE; counter does not wrap into a new write.
REQ-030 busy=1 in ACCEPT and WRITE; done=1 only in DONE.
REQ-031 Maximum throughput one instruction per two cycles.

Reset
REQ-032 Reset asserted at any time, including mid-WRITE, SHALL force IDLE and zero every output: in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_overflow, checksum.
REQ-033 No memory write SHALL occur in the cycle reset deasserts.

Configuration
REQ-034 Macro INSTR_LOADER_CHECKSUM_EN defined: checksum XORs each written imem_wdata at WRITE, cleared on start.
REQ-035 Macro undefined: checksum port present and constant 0; no checksum register synthesized.

Structure
REQ-036 Shared package mips_pkg SHALL hold the opcode constants and the in_class encoding, shared with the controller decoder.
REQ-037 Combinational field packing SHALL live in sub-module instr_encoder; instr_loader holds FSM, counter, and flags.

Verification
REQ-038 start; R-type rs=1,rt=2,rd=3,shamt=0,funct=100000 -> imem_we one cycle later, addr 0, wdata 0x00221820.
REQ-039 LW rs=0,rt=8,imm=0x0004, in_last -> wdata 0x8C080004 at addr 0; done=1, busy=0.
REQ-040 J jaddr=0x0000010 then BEQ rs=1,rt=2,imm=0xFFFF, in_last -> 0x08000010 at 0, 0x1022FFFF at 1.
REQ-041 ADDR_W=2, five legal bundles without in_last -> four writes at addr 0-3, err_overflow=1, done=1, fifth never accepted.
REQ-042 in_class=7 between two ADDI words -> err_illegal=1, ADDI words at consecutive addresses 0,1; reset during WRITE -> all outputs 0, no further imem_we.
